router_merge_fifo: RTL

//  Parametrised N-input merge stage for the mesh router; successor to the fixed 2-input forward merges.

---
 rtl/router_pkg.sv | 21 ++
 rtl/router_rr_arbiter.sv | 36 +++
 rtl/router_merge_fifo.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/router_pkg.sv
// Shared constants and helpers for the mesh router merge stage.
package router_pkg;

   localparam int STAT_W    = 16;
   localparam int OFS_MAX_W = 32;

   // Moves a sign-extended hop offset one step toward zero.
   function automatic logic signed [OFS_MAX_W-1:0] ofs_step(input logic signed [OFS_MAX_W-1:0] ofs);
      if (ofs > 0) begin
         return ofs - 1;
      end else if (ofs < 0) begin
         return ofs + 1;
      end
      return ofs;
   endfunction

   function automatic bit is_pow2(input int unsigned value);
      return (value != 0) && ((value & (value - 1)) == 0);
   endfunction

endpackage

// File: rtl/router_rr_arbiter.sv
// Round-robin arbiter: picks the lowest requesting index at or after ptr, wrapping.
module router_rr_arbiter #(
   parameter int  NUM_IN = 3,
   localparam int PTR_W  = (NUM_IN > 1) ? $clog2(NUM_IN) : 1
) (
   input  logic [NUM_IN-1:0] req,
   input  logic [PTR_W-1:0]  ptr,
   output logic [NUM_IN-1:0] grant,
   output logic [PTR_W-1:0]  winner,
   output logic              valid
);

   logic [PTR_W:0]   sum;
   logic [PTR_W-1:0] slot;

   always_comb begin
      grant  = '0;
      winner = '0;
      valid  = 1'b0;
      sum    = '0;
      slot   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
         sum = {1'b0, ptr} + (PTR_W+1)'(k);
         if (sum >= (PTR_W+1)'(NUM_IN)) begin
            sum = sum - (PTR_W+1)'(NUM_IN);
         end
         slot = sum[PTR_W-1:0];
         if (!valid && req[slot]) begin
            grant[slot] = 1'b1;
            winner      = slot;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/router_merge_fifo.sv
// N-input round-robin merge into an FWFT output FIFO, stepping the hop offset toward zero.
// Define ROUTER_MERGE_STATS_EN to build the saturating per-input grant counters.
module router_merge_fifo
   import router_pkg::*;
#(
   parameter int NUM_IN       = 3,
   parameter int PACKET_WIDTH = 30,
   parameter int OFS_MSB      = 29,
   parameter int OFS_LSB      = 21,
   parameter int DEPTH        = 4
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [NUM_IN*PACKET_WIDTH-1:0] din,
   input  logic [NUM_IN-1:0]              empty_in,
   output logic [NUM_IN-1:0]              ren_out,
   output logic [PACKET_WIDTH-1:0]        dout,
   output logic                           empty_out,
   input  logic                           ren_in,
   output logic                           full,
   output logic [$clog2(DEPTH):0]         count,
   output logic                           head_at_dest,
   output logic [NUM_IN*STAT_W-1:0]       stat_grants
);

   localparam int AW    = $clog2(DEPTH);
   localparam int CW    = AW + 1;
   localparam int PTR_W = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;
   localparam int OFS_W = OFS_MSB - OFS_LSB + 1;

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_depth_check
      $error("router_merge_fifo: DEPTH must be a power of two >= 2");
   end

   logic [PACKET_WIDTH-1:0]    mem_q [DEPTH];
   logic [PACKET_WIDTH-1:0]    mem_d [DEPTH];
   logic [AW-1:0]              wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]              count_q, count_d;
   logic [PTR_W-1:0]           ptr_q, ptr_d;
   logic [PACKET_WIDTH-1:0]    dout_q, dout_d;

   logic [NUM_IN-1:0]          grant;
   logic [PTR_W-1:0]           winner;
   logic                       grant_valid;
   logic                       push, pop;
   logic [PACKET_WIDTH-1:0]    win_pkt, wdata;
   logic signed [OFS_MAX_W-1:0] stepped;

   router_rr_arbiter #(.NUM_IN(NUM_IN)) u_arb (
      .req    (~empty_in),
      .ptr    (ptr_q),
      .grant  (grant),
      .winner (winner),
      .valid  (grant_valid)
   );

   // Occupancy is checked before any same-cycle pop, so a full FIFO never accepts a write.
   assign push    = grant_valid && (count_q != CW'(DEPTH)) && !reset;
   assign pop     = ren_in && (count_q != '0);
   assign ren_out = push ? grant : '0;

   always_comb begin
      win_pkt = din[int'(winner)*PACKET_WIDTH +: PACKET_WIDTH];
      stepped = ofs_step(OFS_MAX_W'(signed'(win_pkt[OFS_MSB:OFS_LSB])));
      wdata   = win_pkt;
      wdata[OFS_MSB:OFS_LSB] = stepped[OFS_W-1:0];
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      ptr_d    = ptr_q;
      dout_d   = dout_q;
      count_d  = count_q + CW'(push) - CW'(pop);
      if (push) begin
         mem_d[wr_ptr_q] = wdata;
         wr_ptr_d        = wr_ptr_q + AW'(1);
         ptr_d           = (winner == PTR_W'(NUM_IN - 1)) ? '0 : winner + PTR_W'(1);
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + AW'(1);
      end
      // dout is a registered copy of the next head; it simply holds when the FIFO drains.
      if (count_q == '0 || (count_q == CW'(1) && pop)) begin
         if (push) begin
            dout_d = wdata;
         end
      end else if (pop) begin
         dout_d = mem_q[rd_ptr_q + AW'(1)];
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         ptr_q    <= '0;
         dout_q   <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
         ptr_q    <= ptr_d;
         dout_q   <= dout_d;
      end
   end

   always_ff @(posedge clk) begin
      mem_q <= mem_d;
   end

   assign dout         = dout_q;
   assign count        = count_q;
   assign empty_out    = (count_q == '0);
   assign full         = (count_q == CW'(DEPTH));
   assign head_at_dest = !empty_out && (dout_q[OFS_MSB:OFS_LSB] == '0);

`ifdef ROUTER_MERGE_STATS_EN
   logic [STAT_W-1:0] stat_q [NUM_IN];
   logic [STAT_W-1:0] stat_d [NUM_IN];

   always_comb begin
      stat_d = stat_q;
      for (int i = 0; i < NUM_IN; i++) begin
         if (ren_out[i] && stat_q[i] != '1) begin
            stat_d[i] = stat_q[i] + STAT_W'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NUM_IN; i++) begin
            stat_q[i] <= '0;
         end
      end else begin
         stat_q <= stat_d;
      end
   end

   always_comb begin
      stat_grants = '0;
      for (int i = 0; i < NUM_IN; i++) begin
         stat_grants[i*STAT_W +: STAT_W] = stat_q[i];
      end
   end
`else
   assign stat_grants = '0;
`endif

endmodule
